regfile_wr_arbiter: RTL and testbench

Write-port arbiter and sequencer for the CPU register file. It shares the single register-file write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback. It drives the 5-to-32 write-enable decoder with a registered address/enable pair, and drives the write-data bus alongside it. Round-robin fairness applies when both requesters contend; writes to register 0 are accepted but suppressed and counted.

---
 rtl/regfile_wr_arbiter_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_if.sv | 44 ++++
 rtl/regfile_wr_arbiter_rr_arb2.sv | 28 ++
 rtl/regfile_wr_arbiter.sv | 73 +++++++
 tb/tb_regfile_wr_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared CPU register-file constants used by the write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);

  // Requester indices; requester 1 is the reset owner of the round-robin pointer.
  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request handshakes plus the decoder/write-data bus of the register file.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              req0_valid;
  reg_addr_t         req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  reg_addr_t         req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              stall;

  reg_addr_t         dec_a;
  logic              dec_en;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  r0_drop_cnt;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  stall,
    output req0_ready, req1_ready,
    output dec_a, dec_en, wr_data, r0_drop_cnt, busy
  );

  // Requester / observer side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output stall,
    input  req0_ready, req1_ready,
    input  dec_a, dec_en, wr_data, r0_drop_cnt, busy
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant plus the last-grant pointer.
module regfile_wr_arbiter_rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  // Grants are masked by reset so requesters never see ready while held in reset.
  always_comb begin
    grant = 2'b00;
    if (rst_n && !stall) begin
      if (valid == 2'b11) grant = (last_grant == REQ_LOAD) ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= REQ_LOAD;
    else if (|grant) last_grant <= grant[1];
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback, one-cycle strobe.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [1:0]        grant;
  logic              xfer;
  reg_addr_t         sel_a;
  logic [DATA_W-1:0] sel_d;
  logic              wr_go;
  logic              drop;

  logic [0:0]        state, state_nxt;
  reg_addr_t         dec_a_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [CNT_W-1:0]  cnt_q;

  regfile_wr_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (bus.stall),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign xfer  = |grant;
  assign sel_a = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_d = grant[1] ? bus.req1_data : bus.req0_data;
  // Register 0 is hardwired: accept the write, never strobe it.
  assign wr_go = xfer && (sel_a != REG_ZERO);
  assign drop  = xfer && (sel_a == REG_ZERO);

  always_comb begin
    state_nxt = ST_IDLE;
    if (wr_go) state_nxt = ST_WRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dec_a_q   <= REG_ZERO;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      if (wr_go) begin
        dec_a_q   <= sel_a;
        wr_data_q <= sel_d;
      end
      if (drop && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.dec_en      = (state == ST_WRITE);
  assign bus.busy        = (state == ST_WRITE);
  assign bus.dec_a       = dec_a_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.r0_drop_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
module tb_regfile_wr_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Winner: -1 none, else the requester index, using "the one not last granted wins".
  function automatic int winner(input logic rn, input logic st, input logic v0,
                                input logic v1, input int last);
    if (!rn || st)     return -1;
    if (v0 && v1)      return (last == 0) ? 1 : 0;
    if (v0)            return 0;
    if (v1)            return 1;
    return -1;
  endfunction

  int          m_last = 1;
  logic        m_en   = 1'b0;
  logic [4:0]  m_a    = '0;
  logic [31:0] m_d    = '0;
  int          m_cnt  = 0;
  int          m_win;
  logic [4:0]  w_a;
  logic [31:0] w_d;

  always_comb begin
    m_win = winner(rst_n, bus.stall, bus.req0_valid, bus.req1_valid, m_last);
    w_a   = (m_win == 1) ? bus.req1_addr : bus.req0_addr;
    w_d   = (m_win == 1) ? bus.req1_data : bus.req0_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1; m_en <= 1'b0; m_a <= '0; m_d <= '0; m_cnt <= 0;
    end else if (m_win >= 0) begin
      m_last <= m_win;
      if (w_a != 0) begin
        m_en <= 1'b1; m_a <= w_a; m_d <= w_d;
      end else begin
        m_en  <= 1'b0;
        m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end else begin
      m_en <= 1'b0;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("rdy0",    64'(bus.req0_ready),  64'(m_win == 0));
    chk("rdy1",    64'(bus.req1_ready),  64'(m_win == 1));
    chk("dec_en",  64'(bus.dec_en),      64'(m_en));
    chk("busy",    64'(bus.busy),        64'(m_en));
    chk("dec_a",   64'(bus.dec_a),       64'(m_a));
    chk("wr_data", 64'(bus.wr_data),     64'(m_d));
    chk("cnt",     64'(bus.r0_drop_cnt), 64'(m_cnt));
  end

  // ---------------- stimulus + literal checks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.stall = 1'b0;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
  endtask

  int   exp_seq [4] = '{1, 5, 2, 6};
  int   a0, a1;
  logic took0, took1;

  initial begin
    idle_inputs();
    // 1. reset: a lone request held during reset must not be readied
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_rst_rdy0",  64'(bus.req0_ready),  64'd0);
    chk("t1_rst_en",    64'(bus.dec_en),      64'd0);
    chk("t1_rst_a",     64'(bus.dec_a),       64'd0);
    chk("t1_rst_data",  64'(bus.wr_data),     64'd0);
    chk("t1_rst_cnt",   64'(bus.r0_drop_cnt), 64'd0);
    chk("t1_rst_busy",  64'(bus.busy),        64'd0);
    rst_n = 1'b1;
    #3;
    chk("t1_rdy0_first", 64'(bus.req0_ready), 64'd1);
    // 2. single write
    step();
    bus.req0_valid = 1'b0;
    chk("t2_en",   64'(bus.dec_en),  64'd1);
    chk("t2_a",    64'(bus.dec_a),   64'd4);
    chk("t2_data", 64'(bus.wr_data), 64'hDEADBEEF);
    step();
    chk("t2_en_off",  64'(bus.dec_en),  64'd0);
    chk("t2_data_hold", 64'(bus.wr_data), 64'hDEADBEEF);

    // 3. contention from a fresh pointer
    idle_inputs();
    pulse_rst();
    a0 = 1; a1 = 5;
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1; bus.req0_addr = 5'(a0); bus.req0_data = 32'(a0 * 16);
      bus.req1_valid = 1'b1; bus.req1_addr = 5'(a1); bus.req1_data = 32'(a1 * 16);
      #3;
      chk("t3_rdy0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      chk("t3_rdy1", 64'(bus.req1_ready), 64'(i % 2 == 1));
      step();
      chk("t3_en", 64'(bus.dec_en), 64'd1);
      chk("t3_a",  64'(bus.dec_a),  64'(exp_seq[i]));
      if (i % 2 == 0) a0++; else a1++;
    end
    idle_inputs();
    step();
    chk("t3_en_off", 64'(bus.dec_en), 64'd0);

    // 4. register-0 drops
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h123;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t4_rdy1", 64'(bus.req1_ready), 64'd1);
      step();
      chk("t4_en", 64'(bus.dec_en), 64'd0);
    end
    bus.req1_valid = 1'b0;
    chk("t4_cnt3", 64'(bus.r0_drop_cnt), 64'd3);

    // 5. stall with both pending; requester 1 was granted last
    bus.stall = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 32'hA0A0;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd11; bus.req1_data = 32'hB1B1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t5_stall_rdy0", 64'(bus.req0_ready), 64'd0);
      chk("t5_stall_rdy1", 64'(bus.req1_ready), 64'd0);
      step();
      chk("t5_stall_en", 64'(bus.dec_en), 64'd0);
    end
    bus.stall = 1'b0;
    #3;
    chk("t5_rel_rdy0", 64'(bus.req0_ready), 64'd1);
    chk("t5_rel_rdy1", 64'(bus.req1_ready), 64'd0);
    step();
    chk("t5_a0",    64'(bus.dec_a),   64'd10);
    chk("t5_data0", 64'(bus.wr_data), 64'hA0A0);
    bus.req0_valid = 1'b0;
    #3;
    chk("t5_rdy1", 64'(bus.req1_ready), 64'd1);
    step();
    chk("t5_a1", 64'(bus.dec_a), 64'd11);
    bus.req1_valid = 1'b0;
    step();
    chk("t5_en_off", 64'(bus.dec_en), 64'd0);

    // 6. reset during a strobe
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99;
    step();
    bus.req1_valid = 1'b0;
    chk("t6_en_before", 64'(bus.dec_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_en_async",   64'(bus.dec_en), 64'd0);
    chk("t6_busy_async", 64'(bus.busy),   64'd0);
    #1;
    rst_n = 1'b1;
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'h2;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h3;
    #3;
    chk("t6_rdy0_after", 64'(bus.req0_ready), 64'd1);
    chk("t6_rdy1_after", 64'(bus.req1_ready), 64'd0);
    step();
    idle_inputs();
    step();

    // Randomized traffic; requesters obey the hold-until-transfer rule.
    took0 = 1'b0; took1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.req0_valid || took0) begin
        bus.req0_valid = ($urandom % 3) != 0;
        bus.req0_addr  = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom % 32);
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || took1) begin
        bus.req1_valid = ($urandom % 3) != 0;
        bus.req1_addr  = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom % 32);
        bus.req1_data  = $urandom;
      end
      bus.stall = ($urandom % 6) == 0;
      #3;
      took0 = bus.req0_valid && bus.req0_ready;
      took1 = bus.req1_valid && bus.req1_ready;
      step();
    end

    // Counter saturation: 300 drops from a cleared count.
    idle_inputs();
    pulse_rst();
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h5;
    repeat (300) step();
    bus.req1_valid = 1'b0;
    chk("t4_sat_cnt", 64'(bus.r0_drop_cnt), 64'd255);
    step();
    chk("t4_sat_hold", 64'(bus.r0_drop_cnt), 64'd255);
    chk("t4_sat_en",   64'(bus.dec_en),      64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
